// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer
// ---------------------------------------------------------------------------
// Iterative 16x16 unsigned multiply / divide controller for the EX stage.
// The single EX-stage ALU is time-shared: while the sequencer is idle (or
// delivering its result) the pipeline's ALU request passes straight through;
// while it is busy the sequencer drives the ALU with its own shift-add or
// restoring-divide steps and holds the pipeline with stall.
//
// Handshake: start is a request sampled only in IDLE. It is accepted on the
// rising edge where state == IDLE. stall is raised combinationally in that
// same cycle so the issuing instruction stays in EX. done is a one-cycle
// pulse and res_hi/res_lo/div_by_zero are valid from that cycle. They hold
// until the next accepted start. start while busy or in DONE is ignored.
//
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   start, mode           request; mode 0 = multiply, 1 = divide
//   opa, opb              multiplicand/dividend, multiplier/divisor
//   ex_first/second/op    pipeline ALU request (pass-through source)
//   alu_first/second/op   to shared ALU
//   alu_result            from shared ALU
//   busy, stall, done     status / pipeline hold / completion pulse
//   res_hi, res_lo        product[31:16]/remainder, product[15:0]/quotient
//   div_by_zero           set with done when a divide had opb == 0
//   fsm_state             current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module alu_muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [WIDTH-1:0] ex_first,
    input  logic [WIDTH-1:0] ex_second,
    input  logic [3:0]       ex_op,
    output logic [WIDTH-1:0] alu_first,
    output logic [WIDTH-1:0] alu_second,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_by_zero,
    output logic [2:0]       fsm_state
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL     = 3'd1,
        DIV_CMP = 3'd2,
        DIV_SUB = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     m_reg;      // multiplicand
    logic [2*WIDTH-1:0]   p_reg;      // {partial sum, remaining multiplier bits}
    logic [WIDTH-1:0]     d_reg;      // divisor
    logic [WIDTH-1:0]     q_reg;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]     r_reg;      // partial remainder
    logic [WIDTH-1:0]     rs_reg;     // shifted remainder held for the subtract step
    logic [3:0]           cnt;

    // Divide: shift next dividend bit into the remainder. rem_msb is the
    // 17th bit; when set, the shifted remainder is certainly >= divisor.
    logic                 rem_msb;
    logic [WIDTH-1:0]     rs_c;
    // Multiply: carry out of the 16-bit add is recovered by an unsigned
    // compare, since the shared ALU returns only 16 bits.
    logic                 mul_carry;
    logic [2*WIDTH-1:0]   p_next;

    assign rem_msb   = r_reg[WIDTH-1];
    assign rs_c      = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign mul_carry = (alu_result < p_reg[2*WIDTH-1:WIDTH]);
    assign p_next    = {mul_carry, alu_result, p_reg[WIDTH-1:1]};

    assign stall     = busy | (start & (state == IDLE));
    assign fsm_state = state;

    // Shared ALU mux
    always_comb begin
        alu_first  = ex_first;
        alu_second = ex_second;
        alu_op     = ex_op;
        case (state)
            MUL: begin
                alu_op     = OP_ADD;
                alu_first  = p_reg[2*WIDTH-1:WIDTH];
                alu_second = p_reg[0] ? m_reg : '0;
            end
            DIV_CMP: begin
                alu_op     = OP_SLT;
                alu_first  = rs_c;
                alu_second = d_reg;
            end
            DIV_SUB: begin
                alu_op     = OP_SUB;
                alu_first  = rs_reg;
                alu_second = d_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            res_hi      <= '0;
            res_lo      <= '0;
            cnt         <= '0;
            m_reg       <= '0;
            p_reg       <= '0;
            d_reg       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            rs_reg      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        if (!mode) begin
                            m_reg <= opa;
                            p_reg <= {{WIDTH{1'b0}}, opb};
                            busy  <= 1'b1;
                            state <= MUL;
                        end else if (opb != '0) begin
                            d_reg <= opb;
                            q_reg <= opa;
                            r_reg <= '0;
                            busy  <= 1'b1;
                            state <= DIV_CMP;
                        end else begin
                            res_lo      <= '1;
                            res_hi      <= opa;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                MUL: begin
                    p_reg <= p_next;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        res_hi <= p_next[2*WIDTH-1:WIDTH];
                        res_lo <= p_next[WIDTH-1:0];
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DIV_CMP: begin
                    q_reg <= q_reg << 1;
                    if (rem_msb || (alu_result == '0)) begin
                        // Shifted remainder >= divisor: subtract next cycle
                        rs_reg <= rs_c;
                        state  <= DIV_SUB;
                    end else begin
                        r_reg <= rs_c;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            res_lo <= q_reg << 1;
                            res_hi <= rs_c;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DIV_SUB: begin
                    // 16-bit wrap is exact: the true difference is < divisor
                    r_reg    <= alu_result;
                    q_reg[0] <= 1'b1;
                    cnt      <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        res_lo <= {q_reg[WIDTH-1:1], 1'b1};
                        res_hi <= alu_result;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= DIV_CMP;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
module tb_alu_muldiv_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, mode;
    logic [15:0] opa, opb;
    logic [15:0] ex_first, ex_second;
    logic [3:0]  ex_op;
    logic [15:0] alu_first, alu_second, alu_result;
    logic [3:0]  alu_op;
    logic        busy, stall, done, div_by_zero;
    logic [15:0] res_hi, res_lo;
    logic [2:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    alu_muldiv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .opa(opa), .opb(opb),
        .ex_first(ex_first), .ex_second(ex_second), .ex_op(ex_op),
        .alu_first(alu_first), .alu_second(alu_second), .alu_op(alu_op),
        .alu_result(alu_result),
        .busy(busy), .stall(stall), .done(done),
        .res_hi(res_hi), .res_lo(res_lo), .div_by_zero(div_by_zero),
        .fsm_state(fsm_state)
    );

    // Shared EX-stage ALU
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_first + alu_second;
            4'b0001: alu_result = alu_first - alu_second;
            4'b0111: alu_result = {15'b0, (alu_first < alu_second)};
            default: alu_result = alu_first ^ alu_second;
        endcase
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  {31'b0, busy}, 32'd0);
        check({tag, "_stall"}, {31'b0, stall}, 32'd0);
        check({tag, "_done"},  {31'b0, done}, 32'd0);
        check({tag, "_dbz"},   {31'b0, div_by_zero}, 32'd0);
        check({tag, "_res"},   {res_hi, res_lo}, 32'd0);
    endtask

    // ---------------- drivers ----------------
    // Issue one operation and follow it to completion. Expectations come from
    // plain arithmetic: a*b, a/b, a%b, and latency 17 + popcount(quotient).
    task automatic run_op(input logic m, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] exp_res;
        int          exp_lat, lat, stall_bad, aluop_bad, subs;
        logic        exp_dbz;
        if (!m) begin
            exp_res = {16'b0, a} * {16'b0, b};
            exp_lat = 17;
            exp_dbz = 1'b0;
        end else if (b == 16'h0) begin
            exp_res = {a, 16'hFFFF};
            exp_lat = 1;
            exp_dbz = 1'b1;
        end else begin
            exp_res = {a % b, a / b};
            exp_lat = 17 + $countones(a / b);
            exp_dbz = 1'b0;
        end
        exp_q.push_back(exp_res);
        ex_first  = 16'($urandom);
        ex_second = 16'($urandom);
        ex_op     = 4'($urandom_range(2, 6));

        @(negedge clk);
        start = 1'b1; mode = m; opa = a; opb = b;
        #1;
        check("stall_req", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 1'($urandom);
        opa   = 16'($urandom);
        opb   = 16'($urandom);

        lat = 0; stall_bad = 0; aluop_bad = 0; subs = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!stall || !busy) stall_bad++;
            if (!m && alu_op != 4'b0000) aluop_bad++;
            if (m) begin
                if (alu_op == 4'b0001) subs++;
                else if (alu_op != 4'b0111) aluop_bad++;
            end
        end
        check("latency", lat, exp_lat);
        check("stall_hold", stall_bad, 0);
        check("alu_op_seq", aluop_bad, 0);
        if (m && b != 16'h0) check("sub_steps", subs, $countones(a / b));
        check("result", {res_hi, res_lo}, exp_q.pop_front());
        check("dbz", {31'b0, div_by_zero}, {31'b0, exp_dbz});
        check("done_stall", {31'b0, stall}, 32'd0);
        check("done_pass_a", {16'b0, alu_first}, {16'b0, ex_first});
        check("done_pass_op", {28'b0, alu_op}, {28'b0, ex_op});
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 32'd0);
        check("hold_res", {res_hi, res_lo}, exp_res);
    endtask

    task automatic pass_check(input logic [15:0] f, input logic [15:0] s, input logic [3:0] op);
        @(negedge clk);
        ex_first = f; ex_second = s; ex_op = op;
        #1;
        check("pass_first",  {16'b0, alu_first},  {16'b0, f});
        check("pass_second", {16'b0, alu_second}, {16'b0, s});
        check("pass_op",     {28'b0, alu_op},     {28'b0, op});
    endtask

    task automatic reset_mid_multiply();
        int done_seen;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; opa = 16'($urandom); opb = 16'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("no_done_after_abort", done_seen, 0);
    endtask

    // ---------------- main ----------------
    initial begin
        rst = 1'b0; start = 1'b0; mode = 1'b0; opa = '0; opb = '0;
        ex_first = '0; ex_second = '0; ex_op = '0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        pass_check(16'd5, 16'd3, 4'b0001);
        for (int i = 0; i < 4; i++)
            pass_check(16'($urandom), 16'($urandom), 4'($urandom));

        run_op(1'b0, 16'h1234, 16'h0010);
        run_op(1'b0, 16'hFFFF, 16'hFFFF);
        run_op(1'b1, 16'd100, 16'd7);
        run_op(1'b1, 16'hFFFF, 16'h8001);
        run_op(1'b1, 16'hABCD, 16'h0000);

        reset_mid_multiply();
        run_op(1'b0, 16'h00FF, 16'h0101);

        for (int i = 0; i < 15; i++)
            run_op(1'b0, 16'($urandom), 16'($urandom));
        for (int i = 0; i < 15; i++) begin
            logic [15:0] b;
            b = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom);
            if (b == 16'h0) b = 16'h1;
            run_op(1'b1, 16'($urandom), b);
        end
        run_op(1'b1, 16'($urandom), 16'h0000);
        run_op(1'b1, 16'h0000, 16'h0001);
        run_op(1'b1, 16'hFFFF, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
